// File: rtl/adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : adder_pipe
// Purpose  : Pipelined add / subtract / saturating-accumulate / clear unit.
//            The operation result is registered when the operands are
//            accepted (stage 1). It then passes through LATENCY-1 further
//            shift stages, and a valid bit travels with it.
//            The accumulator and its sticky saturation flag update on the
//            accepting edge, so back-to-back accumulates chain without a
//            bubble.
// Ports    : clk       - rising-edge clock
//            rst_n     - asynchronous active-low reset
//            in_valid  - operands/mode valid this cycle
//            mode      - 00 add, 01 sub, 10 accumulate, 11 clear
//            in1, in2  - unsigned operands (in2 unused by accumulate/clear)
//            out       - result, WIDTH+ACC_EXT bits, holds between results
//            out_valid - out carries a new result this cycle
//            ovf       - sticky accumulator saturation flag (not pipelined)
// Revision : 1.0 - initial release
// ============================================================================
module adder_pipe #(
    parameter int WIDTH   = 10,
    parameter int ACC_EXT = 4,
    parameter int LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [1:0]               mode,
    input  logic [WIDTH-1:0]         in1,
    input  logic [WIDTH-1:0]         in2,
    output logic [WIDTH+ACC_EXT-1:0] out,
    output logic                     out_valid,
    output logic                     ovf
);

    localparam int OW = WIDTH + ACC_EXT;

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_ACC = 2'b10;
    localparam logic [1:0] MODE_CLR = 2'b11;

    logic [OW-1:0]      acc_q;
    logic [OW-1:0]      acc_d;
    logic               ovf_q;
    logic               ovf_d;
    logic [OW-1:0]      res_q [LATENCY];
    logic [OW-1:0]      res_d [LATENCY];
    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] vld_d;

    logic [OW-1:0]      a_ext;
    logic [OW-1:0]      b_ext;
    logic [OW:0]        acc_sum;
    logic [OW-1:0]      op_result;

    always_comb begin
        a_ext     = {{ACC_EXT{1'b0}}, in1};
        b_ext     = {{ACC_EXT{1'b0}}, in2};
        // One spare bit above OW catches the carry that means saturation.
        acc_sum   = {1'b0, acc_q} + {1'b0, a_ext};
        op_result = '0;
        acc_d     = acc_q;
        ovf_d     = ovf_q;

        case (mode)
            MODE_ADD: op_result = a_ext + b_ext;
            MODE_SUB: op_result = a_ext - b_ext;
            MODE_ACC: op_result = acc_sum[OW] ? {OW{1'b1}} : acc_sum[OW-1:0];
            default:  op_result = '0;
        endcase

        if (in_valid && (mode == MODE_ACC)) begin
            acc_d = op_result;
            if (acc_sum[OW]) begin
                ovf_d = 1'b1;
            end
        end
        if (in_valid && (mode == MODE_CLR)) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end

        // Data registers load only with a valid result so that out holds
        // its last value between results; valid bits shift every cycle.
        vld_d[0] = in_valid;
        res_d[0] = in_valid ? op_result : res_q[0];
        for (int k = 1; k < LATENCY; k++) begin
            vld_d[k] = vld_q[k-1];
            res_d[k] = vld_q[k-1] ? res_q[k-1] : res_q[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            vld_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                res_q[k] <= '0;
            end
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            vld_q <= vld_d;
            for (int k = 0; k < LATENCY; k++) begin
                res_q[k] <= res_d[k];
            end
        end
    end

    assign out       = res_q[LATENCY-1];
    assign out_valid = vld_q[LATENCY-1];
    assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_pipe
// Purpose  : Self-checking bench for adder_pipe. A vector table drives the
//            main instance (WIDTH=10, ACC_EXT=4, LATENCY=2). Expected results
//            are queued at drive time and popped when out_valid is seen,
//            which checks the value, the latency and the ordering.
//            Hand-written sequences cover reset mid-pipeline and a LATENCY=1
//            and LATENCY=4 sweep at WIDTH=16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_pipe;

    localparam int W  = 10;
    localparam int E  = 4;
    localparam int L  = 2;
    localparam int OW = W + E;

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] ACC = 2'b10;
    localparam logic [1:0] CLR = 2'b11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [1:0]    mode;
    logic [W-1:0]  in1;
    logic [W-1:0]  in2;
    logic [OW-1:0] out;
    logic          out_valid;
    logic          ovf;

    logic          s_valid;
    logic [15:0]   s_in1;
    logic [15:0]   s_in2;
    logic [19:0]   out_l1;
    logic [19:0]   out_l4;
    logic          v_l1;
    logic          v_l4;
    logic          ovf_l1;
    logic          ovf_l4;

    always #5 clk = ~clk;

    adder_pipe #(.WIDTH(W), .ACC_EXT(E), .LATENCY(L)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode),
        .in1(in1), .in2(in2), .out(out), .out_valid(out_valid), .ovf(ovf)
    );

    adder_pipe #(.WIDTH(16), .ACC_EXT(4), .LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .mode(2'b00),
        .in1(s_in1), .in2(s_in2), .out(out_l1), .out_valid(v_l1), .ovf(ovf_l1)
    );

    adder_pipe #(.WIDTH(16), .ACC_EXT(4), .LATENCY(4)) u_l4 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .mode(2'b00),
        .in1(s_in1), .in2(s_in2), .out(out_l4), .out_valid(v_l4), .ovf(ovf_l4)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [OW-1:0] val;
        int            at;
    } exp_t;

    typedef struct {
        logic [1:0]    m;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [OW-1:0] e;
        logic          eo;
    } vec_t;

    exp_t sb[$];
    exp_t got;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    // Drive one operation for one edge and queue its expected result.
    task automatic send(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [OW-1:0] e, input logic eo);
        exp_t x;
        mode     = m;
        in1      = a;
        in2      = b;
        in_valid = 1'b1;
        x.val    = e;
        x.at     = cyc + L;
        sb.push_back(x);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("ovf_after_accept", {31'd0, ovf}, {31'd0, eo});
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                check("stray_out_valid", 32'd1, 32'd0);
            end else begin
                got = sb.pop_front();
                check("out_value", {18'd0, out}, {18'd0, got.val});
                check("out_latency", cyc, got.at);
            end
        end
    end

    initial begin
        int acc_c;
        int d;
        int tot;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        mode     = ADD;
        in1      = '0;
        in2      = '0;
        s_valid  = 1'b0;
        s_in1    = '0;
        s_in2    = '0;

        #12;
        check("reset_out", {18'd0, out}, 32'd0);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_ovf", {31'd0, ovf}, 32'd0);
        check("reset_out_l4", {12'd0, out_l4}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Vector table: add, sub, saturating accumulate, clear, throughput.
        vecs.push_back('{ADD, 10'd10,   10'd20,  14'd30,    1'b0});
        vecs.push_back('{ADD, 10'd1023, 10'd1023, 14'd2046, 1'b0});
        vecs.push_back('{SUB, 10'd123,  10'd456, 14'h3EB3,  1'b0});
        vecs.push_back('{SUB, 10'd456,  10'd123, 14'd333,   1'b0});
        vecs.push_back('{CLR, 10'd77,   10'd88,  14'd0,     1'b0});
        for (int k = 1; k <= 17; k++) begin
            tot = k * 1023;
            vecs.push_back('{ACC, 10'd1023, 10'd5,
                             (tot > 16383) ? 14'h3FFF : tot[13:0],
                             (tot > 16383) ? 1'b1 : 1'b0});
        end
        vecs.push_back('{SUB, 10'd456,  10'd123, 14'd333,   1'b1});
        vecs.push_back('{ACC, 10'd1,    10'd0,   14'h3FFF,  1'b1});
        vecs.push_back('{CLR, 10'd0,    10'd0,   14'd0,     1'b0});
        for (int k = 1; k <= 5; k++) begin
            tot = 100 + k;
            vecs.push_back('{ADD, 10'(k), 10'd100, tot[13:0], 1'b0});
        end

        foreach (vecs[i]) send(vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].e, vecs[i].eo);
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("out_holds_last", {18'd0, out}, 32'd105);

        // Reset while 10+20 is still in flight.
        send(ADD, 10'd10, 10'd20, 14'd30, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_out", {18'd0, out}, 32'd0);
        check("async_reset_out_valid", {31'd0, out_valid}, 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send(ADD, 10'd123, 10'd456, 14'd579, 1'b0);
        send(ACC, 10'd5, 10'd0, 14'd5, 1'b0);
        drain();

        // LATENCY=1 and LATENCY=4 sweep at WIDTH=16.
        @(posedge clk);
        #1;
        s_in1   = 16'd40000;
        s_in2   = 16'd30000;
        s_valid = 1'b1;
        acc_c   = cyc + 1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        do begin
            @(negedge clk);
            d = cyc - acc_c;
            check("l1_out_valid", {31'd0, v_l1}, (d == 0) ? 32'd1 : 32'd0);
            check("l4_out_valid", {31'd0, v_l4}, (d == 3) ? 32'd1 : 32'd0);
            if (d == 0) check("l1_out", {12'd0, out_l1}, 32'd70000);
            if (d == 3) check("l4_out", {12'd0, out_l4}, 32'd70000);
        end while (d < 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adder_pipe.md
# adder_pipe

Parametrised, pipelined add/subtract/accumulate unit; the next generation of the team's registered 10-bit adder. Widens to any operand width, adds a configurable pipeline latency with a valid strobe, and adds subtract, saturating-accumulate and clear modes. It sits between operand-producing datapath logic and any consumer that needs a registered arithmetic result, with a validity flag accompanying the result.

## Interface
- WIDTH, 10, operand width in bits (>= 2)
- ACC_EXT, 4, extra result bits above WIDTH (>= 1); result width OW = WIDTH + ACC_EXT
- LATENCY, 2, cycles from accepted input to out_valid (>= 1)

One clock; reset is asynchronous and active-low.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and mode valid this cycle
- mode  in  2  00 add, 01 sub, 10 accumulate, 11 clear
- in1  in  WIDTH  operand A, unsigned
- in2  in  WIDTH  operand B, unsigned (ignored in accumulate/clear)
- out  out  OW  result
- out_valid  out  1  out carries a new result this cycle
- ovf  out  1  sticky accumulator saturation flag

## Operation
- Stage 1 (input register) samples in1, in2 and mode on the rising clk edge when in_valid=1. When in_valid=0, it captures nothing and the accumulator is unchanged.
- Result computed from the stage-1 values:
  - add: zero-extend in1 and in2 to OW, then sum (cannot overflow, since ACC_EXT >= 1).
  - sub: in1 - in2 in OW-bit two's complement (negative results are sign-correct across OW bits).
  - accumulate: acc_next = acc + zero-extended in1.
    - If the true sum exceeds 2^OW - 1, acc_next = 2^OW - 1 (all ones) and ovf is set to 1.
    - Once saturated, further accumulates keep acc at all ones.
    - The result is acc_next.
  - clear: acc = 0, ovf = 0, result = 0.
- The accumulator register (OW bits) updates in the same cycle the accumulate/clear operation is accepted. Back-to-back accumulates each see the previous update, with no bubble required.
- add and sub leave acc and ovf untouched.
- The result plus a valid bit pass through LATENCY-1 further register stages, forming a shift pipeline. There is no stall/back-pressure; one result emerges per accepted input, in order.
- out updates only when a valid result reaches the output stage; otherwise out holds its last value.
- ovf reflects the accumulator state immediately; it is not pipelined with results.

## Timing
- Input accepted at edge N -> out/out_valid presented after edge N+LATENCY-1 and sampled valid at edge N+LATENCY. With LATENCY=1, out is registered directly from stage 1.
- out_valid is high for exactly one cycle per accepted input. Continuous in_valid gives continuous out_valid (full throughput).
- ovf sets after the edge that accepts the saturating accumulate. It clears only on clear mode or reset.
- Reset (rst_n=0, asynchronous, any time):
  - out=0, out_valid=0, ovf=0, acc=0, all pipeline valid bits=0.
  - In-flight results are discarded; nothing emerges after reset release until new inputs arrive.
- First input is accepted on the first rising edge with rst_n=1 and in_valid=1.
- mode and operands are don't-care while in_valid=0.

## Test plan
- Add: WIDTH=10, LATENCY=2, ACC_EXT=4, after reset.
  - in1=10, in2=20, mode=00 for 1 cycle -> out=30, out_valid high for exactly one cycle, 2 edges later.
  - in1=1023, in2=1023 -> out=2046.
- Sub: in1=123, in2=456, mode=01 -> out=14'h3EB3 (-333).
  - in1=456, in2=123 -> out=333.
  - ovf unchanged in both cases.
- Accumulate with saturation: clear, then 17 back-to-back accumulates of in1=1023.
  - Outputs 1023, 2046, … 16368.
  - 17th output=16383 with ovf=1.
  - A further clear -> out=0, ovf=0.
- Throughput/order: 5 consecutive cycles of add with in1=1..5, in2=100.
  - out_valid high for 5 consecutive cycles; outs 101..105 in order; no gaps or duplicates.
- Reset mid-pipeline: accept an add of 10+20, then assert rst_n=0 before out_valid.
  - out=0, out_valid=0 immediately, with no clock required.
  - After release, no stale 30 ever appears.
  - Apply 123+456 -> 579 after LATENCY.
- Parameter sweep: LATENCY=1 and LATENCY=4 with WIDTH=16.
  - 40000+30000 -> out=70000 exactly LATENCY edges after acceptance.
